pic_priority_arbiter: RTL

- Clocked interrupt-request arbiter for the 8259A PIC. It owns the IRR and ISR, applies IMR and special-mask filtering, resolves rotating priority, and presents one winning request to the control logic.
- The control logic sequences it with latch_in_service, end_of_interrupt, clear_interrupt_request, freeze and priority_rotate, and reads back highest_level_in_service.
- It is the shared-resource scheduler among the eight IR lines.

---
 rtl/pic_8259_pkg.sv | 32 +++
 rtl/pic_priority_select.sv | 20 ++
 rtl/pic_priority_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/pic_8259_pkg.sv
// Shared constants and rotate/rank helpers for the 8259A priority arbiter.
package pic_8259_pkg;

  localparam int unsigned NUM_IR = 8;

  function automatic logic [7:0] rotate_right8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} >> n;
    return d[7:0];
  endfunction

  function automatic logic [7:0] rotate_left8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // Lower rank means higher priority; level (rotate+1) mod 8 has rank 0.
  function automatic logic [2:0] rank_of(input logic [2:0] level, input logic [2:0] priority_rotate);
    return level - priority_rotate - 3'd1;
  endfunction

  function automatic logic [2:0] level_of(input logic [7:0] one_hot);
    logic [2:0] l;
    l = '0;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      if (one_hot[i]) l = i[2:0];
    end
    return l;
  endfunction

endpackage

// File: rtl/pic_priority_select.sv
// Rotating-priority resolver: returns the one-hot highest-priority set bit, or zero.
module pic_priority_select
  import pic_8259_pkg::*;
(
  input  logic [NUM_IR-1:0] vector,
  input  logic [2:0]        priority_rotate,
  output logic [NUM_IR-1:0] one_hot
);

  logic [2:0] shift;
  logic [7:0] rotated;
  logic [7:0] lowest;

  // Rotating by rotate+1 puts the highest-priority level at bit 0.
  assign shift   = priority_rotate + 3'd1;
  assign rotated = rotate_right8(vector, shift);
  assign lowest  = rotated & (~rotated + 8'd1);
  assign one_hot = rotate_left8(lowest, shift);

endmodule

// File: rtl/pic_priority_arbiter.sv
// 8259A IRR/ISR owner: request capture, masking, nesting check and registered grant.
module pic_priority_arbiter
  import pic_8259_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_IR-1:0] interrupt_request_pin,
  input  logic              level_or_edge_triggered_config,
  input  logic              special_fully_nest_config,
  input  logic              freeze,
  input  logic [NUM_IR-1:0] clear_interrupt_request,
  input  logic [NUM_IR-1:0] interrupt_mask,
  input  logic              special_mask_mode,
  input  logic [NUM_IR-1:0] interrupt_special_mask,
  input  logic              latch_in_service,
  input  logic [NUM_IR-1:0] end_of_interrupt,
  input  logic [2:0]        priority_rotate,
  output logic [NUM_IR-1:0] interrupt_request_register,
  output logic [NUM_IR-1:0] in_service_register,
  output logic [NUM_IR-1:0] interrupt,
  output logic [NUM_IR-1:0] highest_level_in_service,
  output logic              interrupt_valid
);

  logic [NUM_IR-1:0] prev_pin;
  logic [NUM_IR-1:0] irr_q, irr_next;
  logic [NUM_IR-1:0] isr_q, isr_next;
  logic [NUM_IR-1:0] int_q;
  logic [NUM_IR-1:0] masked_isr;
  logic [NUM_IR-1:0] candidate;
  logic [NUM_IR-1:0] hlis;
  logic [NUM_IR-1:0] grant;
  logic [2:0]        cand_rank;
  logic [2:0]        hlis_rank;

  always_comb begin
    irr_next = irr_q;
    for (int unsigned i = 0; i < NUM_IR; i++) begin
      if (clear_interrupt_request[i])
        irr_next[i] = 1'b0;
      else if (freeze)
        irr_next[i] = irr_q[i];
      else if (level_or_edge_triggered_config)
        irr_next[i] = interrupt_request_pin[i];
      else if (interrupt_request_pin[i] && !prev_pin[i])
        irr_next[i] = 1'b1;
      else if (!interrupt_request_pin[i])
        irr_next[i] = 1'b0;
    end
  end

  assign isr_next   = (isr_q & ~end_of_interrupt) | (latch_in_service ? int_q : '0);
  assign masked_isr = special_mask_mode ? (isr_q & ~interrupt_special_mask) : isr_q;

  pic_priority_select u_select_irr (
    .vector          (irr_q & ~interrupt_mask),
    .priority_rotate (priority_rotate),
    .one_hot         (candidate)
  );

  pic_priority_select u_select_isr (
    .vector          (masked_isr),
    .priority_rotate (priority_rotate),
    .one_hot         (hlis)
  );

  // A non-zero masked ISR always yields a non-zero hlis, so its rank is meaningful.
  always_comb begin
    grant     = '0;
    cand_rank = rank_of(level_of(candidate), priority_rotate);
    hlis_rank = rank_of(level_of(hlis), priority_rotate);
    if (candidate != '0) begin
      if (masked_isr == '0)
        grant = candidate;
      else if ((cand_rank < hlis_rank) ||
               (special_fully_nest_config && (cand_rank == hlis_rank)))
        grant = candidate;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_pin <= '0;
      irr_q    <= '0;
      isr_q    <= '0;
      int_q    <= '0;
    end else begin
      prev_pin <= interrupt_request_pin;
      irr_q    <= irr_next;
      isr_q    <= isr_next;
      if (!freeze) int_q <= grant;
    end
  end

  assign interrupt_request_register = irr_q;
  assign in_service_register        = isr_q;
  assign interrupt                  = int_q;
  assign highest_level_in_service   = hlis;
  assign interrupt_valid            = |int_q;

endmodule
